// File: rtl/cnn_mem_arbiter.sv
// Round-robin arbiter granting the single-port CNN memory to the control/datapath
// port (0) or the window-fetch engine (1), one access at a time, with a stall timeout.
module cnn_mem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              err,
    output logic              timeout_sticky
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t            r_state;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [1:0]        r_grant;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_busy;
    logic              r_done0;
    logic              r_done1;
    logic              r_err;
    logic              r_sticky;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic w_any_req;
    logic w_pick1;
    logic w_winner;
    logic w_timeout;

    // Port 1 wins when it is the only requester, or on a tie when port 0 went last.
    assign w_any_req = req0_valid | req1_valid;
    assign w_pick1   = req1_valid & (~req0_valid | ~r_last_grant);
    assign w_winner  = r_grant[1];
    assign w_timeout = (r_wait_cnt == CNT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_wait_cnt   <= '0;
            r_grant      <= 2'b00;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_err        <= 1'b0;
            r_sticky     <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            // NOTE: pulse outputs default low here and are raised only on the completing edge.
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant     <= w_pick1 ? 2'b10 : 2'b01;
                        r_mem_addr  <= w_pick1 ? req1_addr  : req0_addr;
                        r_mem_wdata <= w_pick1 ? req1_wdata : req0_wdata;
                        r_mem_we    <= w_pick1 ? req1_we    : req0_we;
                        r_mem_req   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_wait_cnt  <= '0;
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ready || w_timeout) begin
                        if (!mem_ready) begin
                            r_err    <= 1'b1;
                            r_sticky <= 1'b1;
                        end
                        // A timed-out access returns zero; a successful write leaves rdata alone.
                        if (!mem_ready || !r_mem_we) begin
                            if (w_winner) r_rdata1 <= mem_ready ? mem_rdata : '0;
                            else          r_rdata0 <= mem_ready ? mem_rdata : '0;
                        end
                        r_done0   <= ~w_winner;
                        r_done1   <= w_winner;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_last_grant <= w_winner;
                    r_grant      <= 2'b00;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req0_done      = r_done0;
    assign req1_done      = r_done1;
    assign req0_rdata     = r_rdata0;
    assign req1_rdata     = r_rdata1;
    assign mem_req        = r_mem_req;
    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign grant          = r_grant;
    assign busy           = r_busy;
    assign err            = r_err;
    assign timeout_sticky = r_sticky;

endmodule

// File: tb/tb_cnn_mem_arbiter.sv
// Directed bench for cnn_mem_arbiter: transaction-level model compared every cycle,
// plus hand-computed latencies, data and grant orders for the planned scenarios.
module tb_cnn_mem_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 16;
    localparam int MAX_WAIT = 15;
    localparam int NEVER    = 1000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req0_valid = 1'b0, req0_we = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic [DATA_W-1:0] req0_wdata = '0;
    logic              req0_done;
    logic [DATA_W-1:0] req0_rdata;
    logic              req1_valid = 1'b0, req1_we = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic [DATA_W-1:0] req1_wdata = '0;
    logic              req1_done;
    logic [DATA_W-1:0] req1_rdata;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic [1:0]        grant;
    logic              busy, err, timeout_sticky;

    cnn_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant), .busy(busy), .err(err), .timeout_sticky(timeout_sticky)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory stand-in: fixed contents, ready on the ready_k-th ACCESS cycle (0-based).
    int ready_k = 0;
    int acc_cnt = 0;
    logic prev_req = 1'b0;
    bit rec_on = 1'b0;
    logic [1:0] gseq[$];

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return (a == 12'h123) ? 16'hBEEF : {4'hC, a};
    endfunction

    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            acc_cnt = prev_req ? acc_cnt + 1 : 0;
            if (!prev_req && rec_on) gseq.push_back(grant);
        end
        mem_ready = mem_req && (acc_cnt == ready_k);
        mem_rdata = mem_word(mem_addr);
        prev_req  = mem_req;
    end

    // Transaction model: phase 0 idle, 1 memory access, 2 response cycle.
    int m_phase = 0, m_owner = 0, m_waited = 0;
    bit m_last = 1'b1, m_abort = 1'b0, m_sticky = 1'b0, m_we = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic [DATA_W-1:0] m_rdata[2] = '{16'h0, 16'h0};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_owner = 0; m_last = 1'b1; m_abort = 1'b0; m_sticky = 1'b0;
            m_rdata[0] = '0; m_rdata[1] = '0;
        end else begin
            case (m_phase)
                0: if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) m_owner = m_last ? 0 : 1;
                    else                          m_owner = req1_valid ? 1 : 0;
                    m_addr   = m_owner ? req1_addr  : req0_addr;
                    m_wdata  = m_owner ? req1_wdata : req0_wdata;
                    m_we     = m_owner ? req1_we    : req0_we;
                    m_waited = 0;
                    m_phase  = 1;
                end
                1: begin
                    m_waited++;
                    if (mem_ready) begin
                        if (!m_we) m_rdata[m_owner] = mem_rdata;
                        m_abort = 1'b0;
                        m_phase = 2;
                    end else if (m_waited == MAX_WAIT) begin
                        m_abort = 1'b1;
                        m_sticky = 1'b1;
                        m_rdata[m_owner] = '0;
                        m_phase = 2;
                    end
                end
                default: begin
                    m_last  = (m_owner == 1);
                    m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        check("mem_req", mem_req, m_phase == 1);
        check("busy", busy, m_phase != 0);
        check("grant", grant, (m_phase == 0) ? 2'b00 : (m_owner == 1 ? 2'b10 : 2'b01));
        check("req0_done", req0_done, (m_phase == 2) && (m_owner == 0));
        check("req1_done", req1_done, (m_phase == 2) && (m_owner == 1));
        check("err", err, (m_phase == 2) && m_abort);
        check("timeout_sticky", timeout_sticky, m_sticky);
        check("req0_rdata", req0_rdata, m_rdata[0]);
        check("req1_rdata", req1_rdata, m_rdata[1]);
        if (m_phase == 1) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
            check("mem_we", mem_we, m_we);
        end
    end

    task automatic drive(input int port, input logic v, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (port == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    // One request: raise valid, scramble inputs once captured, wait for done, drop valid.
    task automatic do_req(input int port, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, output logic [DATA_W-1:0] rd,
                          output int lat, output logic e, output logic [ADDR_W-1:0] o_addr,
                          output logic o_we, output logic [DATA_W-1:0] o_wdata);
        int  n0;
        bit  seen = 1'b0;
        bit  got  = 1'b0;
        rd = '0; lat = -1; e = 1'b0; o_addr = '0; o_we = 1'b0; o_wdata = '0;
        drive(port, 1'b1, we, addr, wdata);
        n0 = cyc;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            if (!seen && mem_req && grant[port]) begin
                seen = 1'b1;
                o_addr = mem_addr; o_we = mem_we; o_wdata = mem_wdata;
                drive(port, 1'b1, ~we, ~addr, ~wdata);
            end
            if (port == 0 ? req0_done : req1_done) begin
                got = 1'b1;
                lat = cyc - n0;
                rd  = (port == 0) ? req0_rdata : req1_rdata;
                e   = err;
            end
        end
        check($sformatf("p%0d_done_within_bound", port), got, 1'b1);
        @(posedge clk); #1;
        drive(port, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic port_loop(input int port, input int n);
        logic [DATA_W-1:0] rd, wd;
        logic [ADDR_W-1:0] oa, a;
        logic e, owe;
        int lat;
        for (int i = 0; i < n; i++) begin
            a = 12'(port * 256 + i * 4 + 1);
            do_req(port, 1'b0, a, '0, rd, lat, e, oa, owe, wd);
            check($sformatf("contention_p%0d_rd%0d", port, i), rd, mem_word(a));
            idle(1);
        end
    endtask

    logic [DATA_W-1:0] rd, owd;
    logic [ADDR_W-1:0] oa;
    logic e, owe;
    int lat;
    bit saw_done;

    initial begin
        #2 reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check("reset_mem_req", mem_req, 1'b0);
        check("reset_grant", grant, 2'b00);
        check("reset_sticky", timeout_sticky, 1'b0);
        check("reset_rdata0", req0_rdata, 16'h0);
        idle(2);

        // Single read, ready two cycles after mem_req.
        ready_k = 2;
        do_req(0, 1'b0, 12'h123, 16'h0, rd, lat, e, oa, owe, owd);
        check("read_addr", oa, 12'h123);
        check("read_we", owe, 1'b0);
        check("read_latency", lat, 4);
        check("read_data", rd, 16'hBEEF);
        check("read_err", e, 1'b0);
        idle(2);

        // Single write, ready in the first access cycle.
        ready_k = 0;
        do_req(1, 1'b1, 12'hFFF, 16'h5A5A, rd, lat, e, oa, owe, owd);
        check("write_addr", oa, 12'hFFF);
        check("write_we", owe, 1'b1);
        check("write_wdata", owd, 16'h5A5A);
        check("write_latency", lat, 2);
        check("write_rdata1_unchanged", req1_rdata, 16'h0);
        idle(2);

        // Contention: alternating grants starting with port 0.
        gseq.delete();
        rec_on = 1'b1;
        fork
            port_loop(0, 4);
            port_loop(1, 4);
        join
        rec_on = 1'b0;
        check("contention_grant_count", gseq.size(), 8);
        for (int i = 0; i < gseq.size() && i < 8; i++)
            check($sformatf("contention_grant%0d", i), gseq[i], (i % 2) ? 2'b10 : 2'b01);
        idle(2);

        // Ready on the last allowed access cycle still succeeds.
        ready_k = MAX_WAIT - 1;
        do_req(1, 1'b0, 12'h0AB, 16'h0, rd, lat, e, oa, owe, owd);
        check("boundary_latency", lat, 16);
        check("boundary_data", rd, 16'hC0AB);
        check("boundary_err", e, 1'b0);
        check("boundary_sticky", timeout_sticky, 1'b0);
        idle(2);

        // Memory never answers: abort after 15 access cycles.
        ready_k = NEVER;
        do_req(0, 1'b0, 12'h200, 16'h0, rd, lat, e, oa, owe, owd);
        check("timeout_latency", lat, 16);
        check("timeout_err", e, 1'b1);
        check("timeout_rdata", rd, 16'h0);
        check("timeout_sticky_set", timeout_sticky, 1'b1);
        idle(2);

        ready_k = 0;
        do_req(0, 1'b0, 12'h321, 16'h0, rd, lat, e, oa, owe, owd);
        check("after_timeout_err", e, 1'b0);
        check("after_timeout_data", rd, 16'hC321);
        check("after_timeout_sticky", timeout_sticky, 1'b1);
        idle(2);

        // Reset in the middle of an access.
        ready_k = NEVER;
        drive(0, 1'b1, 1'b0, 12'h055, 16'h0);
        for (int i = 0; i < 10 && !mem_req; i++) idle(1);
        check("pre_reset_mem_req", mem_req, 1'b1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("async_reset_mem_req", mem_req, 1'b0);
        check("async_reset_grant", grant, 2'b00);
        check("async_reset_busy", busy, 1'b0);
        check("async_reset_sticky", timeout_sticky, 1'b0);
        drive(0, 1'b0, 1'b0, '0, '0);
        idle(2);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            if (req0_done || req1_done) saw_done = 1'b1;
        end
        check("no_done_after_reset", saw_done, 1'b0);

        ready_k = 0;
        gseq.delete();
        rec_on = 1'b1;
        fork
            port_loop(0, 1);
            port_loop(1, 1);
        join
        rec_on = 1'b0;
        check("post_reset_grant_count", gseq.size(), 2);
        if (gseq.size() >= 2) begin
            check("post_reset_first_grant", gseq[0], 2'b01);
            check("post_reset_second_grant", gseq[1], 2'b10);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn_mem_arbiter.md
Name: cnn_mem_arbiter

Overview:
- Two-requester arbiter sharing the single-port 16-bit/4096-word CNN memory between the control-unit/datapath port (port 0) and the convolution window-fetch engine (port 1).
- Round-robin grant, one outstanding access at a time, completion handshake on the memory's mem_ready.
- Holds address, write data and write-enable stable for the full access.
- Aborts with an error flag if memory stalls beyond a programmable bound.

Parameters:
- ADDR_W, 12, memory address width.
- DATA_W, 16, memory data width.
- MAX_WAIT, 15, ACCESS cycles without mem_ready before timeout abort (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  port 0 request; held high until req0_done.
- req0_we  input  1  port 0 write (1) / read (0).
- req0_addr  input  ADDR_W  port 0 address.
- req0_wdata  input  DATA_W  port 0 write data.
- req0_done  output  1  one-cycle completion pulse, port 0.
- req0_rdata  output  DATA_W  port 0 read data, valid when req0_done is high.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_done, req1_rdata: same as port 0, for port 1.
- mem_req  output  1  access in progress to memory.
- mem_we  output  1  write strobe, qualified by mem_req.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, sampled when mem_ready is high.
- mem_ready  input  1  memory completes the current access this cycle.
- grant  output  2  one-hot owner of the current access; 00 when idle.
- busy  output  1  high in ACCESS and RESP.
- err  output  1  pulses with done when the access timed out.
- timeout_sticky  output  1  set on any timeout; cleared only by reset.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; last_grant=port 1, so port 0 wins the first tie.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, grant, busy, done, err, rdata, timeout_sticky.
  - Reset mid-access abandons the transaction; no done is issued.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - No valid request: stay in IDLE.
  - Exactly one valid request: grant that port.
  - Both valid: grant the port that is not last_grant.
  - On grant: register addr, wdata and we from the winner into mem_addr, mem_wdata and mem_we; set grant; clear wait counter; go to ACCESS.
- ACCESS:
  - mem_req=1; mem_addr, mem_wdata and mem_we are constant for the whole state.
  - Requester inputs are ignored after capture.
  - mem_ready=1: for a read, latch mem_rdata into the winner's rdata register; go to RESP.
  - Otherwise increment the wait counter.
  - Counter reaches MAX_WAIT without mem_ready: set abort flag and timeout_sticky; winner's rdata=0; go to RESP.
  - mem_ready in the same cycle the counter reaches MAX_WAIT: counts as success, no timeout.
- RESP:
  - mem_req=0.
  - winner's done=1 for exactly one cycle.
  - err=1 only if aborted.
  - last_grant updated to the winner; go to IDLE. grant clears to 00 on leaving RESP.
- Requesters drop valid the cycle after done, so valid sampled in the following IDLE is a new request.
- rdata for a port holds its last value until that port's next read completes. Writes do not change rdata.
- Latency: valid seen in IDLE at cycle t -> mem_req high from t+1 -> mem_ready at t+1+k (k>=0) -> done at t+2+k. Minimum 3 cycles per access.
- Back-to-back: a request pending during RESP is granted in the following IDLE cycle. Gap of one idle cycle between accesses.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1; neither port waits more than one access.
- mem_ready outside ACCESS is ignored.

Test Plan:
- Single read: req0 read addr 0x123; memory returns 0xBEEF with mem_ready 2 cycles after mem_req -> mem_addr=0x123, mem_we=0; req0_done at t+4; req0_rdata=0xBEEF; err=0.
- Single write: req1 write 0x5A5A to 0xFFF; mem_ready same cycle as mem_req -> mem_we=1, mem_wdata=0x5A5A held; req1_done at t+2; req1_rdata unchanged.
- Contention: both valid from reset, each issuing 4 reads (mem_ready immediate) -> grant sequence 01,10,01,10,01,10,01,10; no starvation.
- Timeout: req0 read, mem_ready never asserted -> after 15 ACCESS cycles req0_done=1, err=1, req0_rdata=0, timeout_sticky=1. A following good access gives err=0 with timeout_sticky still 1.
- Boundary: mem_ready arrives on wait cycle 15 -> success; data latched; err=0; timeout_sticky=0.
- Reset mid-ACCESS: assert reset while mem_req=1 -> mem_req, grant and busy go 0 immediately (asynchronously); no done pulse. The next request after reset is served normally with port 0 priority.
